// File: rtl/control_multi_fsm_pkg.sv
// Shared constants for the multicycle RISC-V control unit: state encoding,
// opcodes, ALU operation codes, trap cause codes and the control word layout.
package Parametros;

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADDR = 4'd2;
    localparam logic [3:0] LOAD    = 4'd3;
    localparam logic [3:0] LOADWB  = 4'd4;
    localparam logic [3:0] STORE   = 4'd5;
    localparam logic [3:0] RTYPE   = 4'd6;
    localparam logic [3:0] ITYPE   = 4'd7;
    localparam logic [3:0] ALUWB   = 4'd8;
    localparam logic [3:0] BRANCH  = 4'd9;
    localparam logic [3:0] JAL     = 4'd10;
    localparam logic [3:0] JALR    = 4'd11;
    localparam logic [3:0] LUI     = 4'd12;
    localparam logic [3:0] CSR     = 4'd13;
    localparam logic [3:0] TRAP    = 4'd14;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] OPAND  = 5'd0;
    localparam logic [4:0] OPOR   = 5'd1;
    localparam logic [4:0] OPXOR  = 5'd2;
    localparam logic [4:0] OPADD  = 5'd3;
    localparam logic [4:0] OPSUB  = 5'd4;
    localparam logic [4:0] OPSLT  = 5'd5;
    localparam logic [4:0] OPSLTU = 5'd6;
    localparam logic [4:0] OPSLL  = 5'd7;
    localparam logic [4:0] OPSRL  = 5'd8;
    localparam logic [4:0] OPSRA  = 5'd9;

    localparam logic [3:0] CAUSE_NONE        = 4'b0000;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'b0010;
    localparam logic [3:0] CAUSE_LOAD_MISAL  = 4'b0100;
    localparam logic [3:0] CAUSE_STORE_MISAL = 4'b0110;
    localparam logic [3:0] CAUSE_ECALL       = 4'b1000;

    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

    typedef struct packed {
        logic       escreveIR;
        logic       escrevePC;
        logic       escrevePCCond;
        logic       escrevePCBack;
        logic [1:0] origAULA;
        logic [1:0] origBULA;
        logic [1:0] mem2Reg;
        logic [1:0] origPC;
        logic       iouD;
        logic       regWrite;
        logic       memWrite;
        logic       memRead;
        logic [4:0] aluControl;
        logic       regWriteCSR;
        logic       instrucaoCSR;
        logic       writeCSROrFPULA;
        logic       desalinhado;
        logic [3:0] writeUcause;
    } ctrlT;

    // Word accesses need both low bits clear, halfwords only bit 0; bytes never trap.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addrLow);
        case (funct3[1:0])
            2'b10:   return addrLow != 2'b00;
            2'b01:   return addrLow[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_multi_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface control_multi_fsm_if;
    logic [31:0] iInstr;
    logic [1:0]  iAddrLow;
    logic        oEscreveIR;
    logic        oEscrevePC;
    logic        oEscrevePCCond;
    logic        oEscrevePCBack;
    logic [1:0]  oOrigAULA;
    logic [1:0]  oOrigBULA;
    logic [1:0]  oMem2Reg;
    logic [1:0]  oOrigPC;
    logic        oIouD;
    logic        oRegWrite;
    logic        oMemWrite;
    logic        oMemRead;
    logic [4:0]  oALUControl;
    logic        oRegWriteCSR;
    logic        oInstrucaoCSR;
    logic        oWriteCSROrFPULA;
    logic        oDesalinhado;
    logic [3:0]  oWriteUcause;

    modport master (
        input  iInstr, iAddrLow,
        output oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
               oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oIouD,
               oRegWrite, oMemWrite, oMemRead, oALUControl,
               oRegWriteCSR, oInstrucaoCSR, oWriteCSROrFPULA,
               oDesalinhado, oWriteUcause
    );

    modport slave (
        output iInstr, iAddrLow,
        input  oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
               oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oIouD,
               oRegWrite, oMemWrite, oMemRead, oALUControl,
               oRegWriteCSR, oInstrucaoCSR, oWriteCSROrFPULA,
               oDesalinhado, oWriteUcause
    );
endinterface

// File: rtl/control_multi_fsm_alu_op_dec.sv
// ALU operation decode for R-type and I-type arithmetic, plus the funct7
// legality check that diverts bad encodings to the illegal-instruction trap.
module alu_op_dec
    import Parametros::*;
(
    input  logic [2:0] iFunct3,
    input  logic [6:0] iFunct7,
    input  logic       iIsRType,
    output logic [4:0] oALUOp,
    output logic       oIllegal
);
    logic alt;
    logic funct7Ok;

    assign alt      = iFunct7[5];
    assign funct7Ok = (iFunct7 == 7'b0000000) || (iFunct7 == 7'b0100000);

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        oALUOp   = OPADD;
        oIllegal = 1'b0;
        case (iFunct3)
            3'b000: oALUOp = (iIsRType && alt) ? OPSUB : OPADD;
            3'b001: oALUOp = OPSLL;
            3'b010: oALUOp = OPSLT;
            3'b011: oALUOp = OPSLTU;
            3'b100: oALUOp = OPXOR;
            3'b101: oALUOp = alt ? OPSRA : OPSRL;
            3'b110: oALUOp = OPOR;
            default: oALUOp = OPAND;
        endcase

        // Immediate shifts reuse the funct7 slot; other I-type ops carry immediate bits there.
        if (iIsRType)
            oIllegal = !funct7Ok;
        else if (iFunct3 == 3'b001)
            oIllegal = (iFunct7 != 7'b0000000);
        else if (iFunct3 == 3'b101)
            oIllegal = !funct7Ok;
    end
endmodule

// File: rtl/control_multi_fsm.sv
// Multicycle RISC-V control FSM: Moore decode of state and IR fields into
// datapath strobes, with a one-cycle TRAP state carrying a latched cause.
module control_multi_fsm
    import Parametros::*;
(
    input  logic                 iCLK,
    input  logic                 iRST,
    control_multi_fsm_if.master  bus
);
    logic [3:0] state, nextState;
    logic [3:0] cause, nextCause;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] decOp;
    logic       decIllegal;
    logic       misal;
    ctrlT       ctrl;

    assign opcode = bus.iInstr[6:0];
    assign funct3 = bus.iInstr[14:12];
    assign misal  = misaligned(funct3, bus.iAddrLow);

    alu_op_dec uAluOpDec (
        .iFunct3  (funct3),
        .iFunct7  (bus.iInstr[31:25]),
        .iIsRType (opcode == OPC_RTYPE),
        .oALUOp   (decOp),
        .oIllegal (decIllegal)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= FETCH;
            cause <= CAUSE_NONE;
        end else begin
            // NOTE: non-blocking so state and cause both update from pre-edge values.
            state <= nextState;
            cause <= (nextState == TRAP) ? nextCause : CAUSE_NONE;
        end
    end

    always_comb begin
        nextState = FETCH;
        nextCause = CAUSE_NONE;
        case (state)
            FETCH:   nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: nextState = MEMADDR;
                    OPC_RTYPE, OPC_ITYPE: begin
                        if (decIllegal) begin
                            nextState = TRAP;
                            nextCause = CAUSE_ILLEGAL;
                        end else begin
                            nextState = (opcode == OPC_RTYPE) ? RTYPE : ITYPE;
                        end
                    end
                    OPC_BRANCH: nextState = BRANCH;
                    OPC_JAL:    nextState = JAL;
                    OPC_JALR:   nextState = JALR;
                    OPC_LUI:    nextState = LUI;
                    OPC_AUIPC:  nextState = ALUWB;
                    OPC_SYSTEM: begin
                        if (funct3 != 3'b000) begin
                            nextState = CSR;
                        end else begin
                            nextState = TRAP;
                            nextCause = (bus.iInstr == INSTR_ECALL) ? CAUSE_ECALL : CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        nextState = TRAP;
                        nextCause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEMADDR: nextState = opcode[5] ? STORE : LOAD;
            LOAD: begin
                nextState = misal ? TRAP : LOADWB;
                nextCause = misal ? CAUSE_LOAD_MISAL : CAUSE_NONE;
            end
            STORE: begin
                nextState = misal ? TRAP : FETCH;
                nextCause = misal ? CAUSE_STORE_MISAL : CAUSE_NONE;
            end
            RTYPE, ITYPE, LUI: nextState = ALUWB;
            default: nextState = FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead       = 1'b1;
                ctrl.escreveIR     = 1'b1;
                ctrl.escrevePCBack = 1'b1;
                ctrl.origAULA      = 2'b01;
                ctrl.origBULA      = 2'b01;
                ctrl.aluControl    = OPADD;
                ctrl.escrevePC     = 1'b1;
            end
            DECODE: begin
                ctrl.origAULA   = 2'b10;
                ctrl.origBULA   = 2'b10;
                ctrl.aluControl = OPADD;
            end
            MEMADDR: begin
                ctrl.origBULA   = 2'b10;
                ctrl.aluControl = OPADD;
            end
            // A misaligned access raises no strobe; the trap takes over next cycle.
            LOAD: begin
                ctrl.iouD    = !misal;
                ctrl.memRead = !misal;
            end
            STORE: begin
                ctrl.iouD     = !misal;
                ctrl.memWrite = !misal;
            end
            LOADWB: begin
                ctrl.mem2Reg  = 2'b10;
                ctrl.regWrite = 1'b1;
            end
            RTYPE: ctrl.aluControl = decOp;
            ITYPE: begin
                ctrl.origBULA   = 2'b10;
                ctrl.aluControl = decOp;
            end
            ALUWB: ctrl.regWrite = 1'b1;
            BRANCH: begin
                ctrl.escrevePCCond = 1'b1;
                ctrl.origPC        = 2'b01;
            end
            JAL: begin
                ctrl.mem2Reg   = 2'b01;
                ctrl.regWrite  = 1'b1;
                ctrl.escrevePC = 1'b1;
                ctrl.origPC    = 2'b01;
            end
            JALR: begin
                ctrl.origBULA   = 2'b10;
                ctrl.aluControl = OPADD;
                ctrl.origPC     = 2'b10;
                ctrl.escrevePC  = 1'b1;
                ctrl.mem2Reg    = 2'b01;
                ctrl.regWrite   = 1'b1;
            end
            LUI: begin
                ctrl.origAULA   = 2'b11;
                ctrl.origBULA   = 2'b10;
                ctrl.aluControl = OPADD;
            end
            CSR: begin
                ctrl.instrucaoCSR    = 1'b1;
                ctrl.regWriteCSR     = 1'b1;
                ctrl.writeCSROrFPULA = 1'b1;
                ctrl.regWrite        = 1'b1;
            end
            TRAP: begin
                ctrl.writeUcause = cause;
                ctrl.desalinhado = 1'b1;
                ctrl.escrevePC   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign bus.oEscreveIR       = ctrl.escreveIR;
    assign bus.oEscrevePC       = ctrl.escrevePC;
    assign bus.oEscrevePCCond   = ctrl.escrevePCCond;
    assign bus.oEscrevePCBack   = ctrl.escrevePCBack;
    assign bus.oOrigAULA        = ctrl.origAULA;
    assign bus.oOrigBULA        = ctrl.origBULA;
    assign bus.oMem2Reg         = ctrl.mem2Reg;
    assign bus.oOrigPC          = ctrl.origPC;
    assign bus.oIouD            = ctrl.iouD;
    assign bus.oRegWrite        = ctrl.regWrite;
    assign bus.oMemWrite        = ctrl.memWrite;
    assign bus.oMemRead         = ctrl.memRead;
    assign bus.oALUControl      = ctrl.aluControl;
    assign bus.oRegWriteCSR     = ctrl.regWriteCSR;
    assign bus.oInstrucaoCSR    = ctrl.instrucaoCSR;
    assign bus.oWriteCSROrFPULA = ctrl.writeCSROrFPULA;
    assign bus.oDesalinhado     = ctrl.desalinhado;
    assign bus.oWriteUcause     = ctrl.writeUcause;
endmodule

// File: tb/tb_control_multi_fsm.sv
// Table-driven bench for control_multi_fsm: one expected control word per
// cycle, plus a hand-written reset-during-LOAD sequence.
module tb_control_multi_fsm;
    import Parametros::*;

    logic iCLK;
    logic iRST;
    control_multi_fsm_if bus ();

    control_multi_fsm dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus.master)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [1:0]  addrLow;
        logic [28:0] expOut;
    } vecT;

    vecT vecs[$];
    int  checks = 0;
    int  passes = 0;
    logic [28:0] obs;

    assign obs = {bus.oEscreveIR, bus.oEscrevePC, bus.oEscrevePCCond, bus.oEscrevePCBack,
                  bus.oOrigAULA, bus.oOrigBULA, bus.oMem2Reg, bus.oOrigPC,
                  bus.oIouD, bus.oRegWrite, bus.oMemWrite, bus.oMemRead, bus.oALUControl,
                  bus.oRegWriteCSR, bus.oInstrucaoCSR, bus.oWriteCSROrFPULA,
                  bus.oDesalinhado, bus.oWriteUcause};

    function automatic logic [28:0] pk(
        input logic ir, pc, pcc, pcb,
        input logic [1:0] oa, ob, m2r, opc,
        input logic iod, rw, mw, mr,
        input logic [4:0] alu,
        input logic rwcsr, icsr, wcsr, des,
        input logic [3:0] uc);
        return {ir, pc, pcc, pcb, oa, ob, m2r, opc, iod, rw, mw, mr, alu, rwcsr, icsr, wcsr, des, uc};
    endfunction

    // Expected control word for each state, written straight from the state table.
    logic [28:0] eFetch, eDecode, eMemAddr, eLoad, eLoadWb, eStore, eAluWb;
    logic [28:0] eBranch, eJal, eJalr, eLui, eCsr, eZero;

    function automatic logic [28:0] eR(input logic [4:0] op);
        return pk(0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0, op, 0,0,0,0, 4'd0);
    endfunction
    function automatic logic [28:0] eI(input logic [4:0] op);
        return pk(0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 0,0,0,0, op, 0,0,0,0, 4'd0);
    endfunction
    function automatic logic [28:0] eT(input logic [3:0] c);
        return pk(0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 5'd0, 0,0,0,1, c);
    endfunction

    task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input string name, input logic [31:0] instr, input logic [1:0] al,
                       input logic [28:0] exp);
        vecT v;
        v.name = name; v.instr = instr; v.addrLow = al; v.expOut = exp;
        vecs.push_back(v);
    endtask

    // Common prefix of every instruction: FETCH then DECODE.
    task automatic addFD(input string name, input logic [31:0] instr, input logic [1:0] al);
        add({name, "_fetch"}, instr, al, eFetch);
        add({name, "_decode"}, instr, al, eDecode);
    endtask

    initial begin
        eFetch   = pk(1,1,0,1, 2'b01,2'b01,2'b00,2'b00, 0,0,0,1, OPADD, 0,0,0,0, 4'd0);
        eDecode  = pk(0,0,0,0, 2'b10,2'b10,2'b00,2'b00, 0,0,0,0, OPADD, 0,0,0,0, 4'd0);
        eMemAddr = pk(0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 0,0,0,0, OPADD, 0,0,0,0, 4'd0);
        eLoad    = pk(0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0,0,1, 5'd0,  0,0,0,0, 4'd0);
        eLoadWb  = pk(0,0,0,0, 2'b00,2'b00,2'b10,2'b00, 0,1,0,0, 5'd0,  0,0,0,0, 4'd0);
        eStore   = pk(0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0,1,0, 5'd0,  0,0,0,0, 4'd0);
        eAluWb   = pk(0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1,0,0, 5'd0,  0,0,0,0, 4'd0);
        eBranch  = pk(0,0,1,0, 2'b00,2'b00,2'b00,2'b01, 0,0,0,0, 5'd0,  0,0,0,0, 4'd0);
        eJal     = pk(0,1,0,0, 2'b00,2'b00,2'b01,2'b01, 0,1,0,0, 5'd0,  0,0,0,0, 4'd0);
        eJalr    = pk(0,1,0,0, 2'b00,2'b10,2'b01,2'b10, 0,1,0,0, OPADD, 0,0,0,0, 4'd0);
        eLui     = pk(0,0,0,0, 2'b11,2'b10,2'b00,2'b00, 0,0,0,0, OPADD, 0,0,0,0, 4'd0);
        eCsr     = pk(0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1,0,0, 5'd0,  1,1,1,0, 4'd0);
        eZero    = '0;

        addFD("add", 32'h002081B3, 2'b00);
        add("add_rtype", 32'h002081B3, 2'b00, eR(OPADD));
        add("add_aluwb", 32'h002081B3, 2'b00, eAluWb);
        addFD("lw", 32'h0000A283, 2'b00);
        add("lw_memaddr", 32'h0000A283, 2'b00, eMemAddr);
        add("lw_load", 32'h0000A283, 2'b00, eLoad);
        add("lw_loadwb", 32'h0000A283, 2'b00, eLoadWb);
        addFD("lwmis", 32'h0000A283, 2'b10);
        add("lwmis_memaddr", 32'h0000A283, 2'b10, eMemAddr);
        add("lwmis_load", 32'h0000A283, 2'b10, eZero);
        add("lwmis_trap", 32'h0000A283, 2'b10, eT(CAUSE_LOAD_MISAL));
        addFD("beq", 32'h00000463, 2'b00);
        add("beq_branch", 32'h00000463, 2'b00, eBranch);
        addFD("bad", 32'hFFFFFFFF, 2'b00);
        add("bad_trap", 32'hFFFFFFFF, 2'b00, eT(CAUSE_ILLEGAL));
        addFD("sub", 32'h402081B3, 2'b00);
        add("sub_rtype", 32'h402081B3, 2'b00, eR(OPSUB));
        add("sub_aluwb", 32'h402081B3, 2'b00, eAluWb);
        addFD("sh", 32'h00109023, 2'b10);
        add("sh_memaddr", 32'h00109023, 2'b10, eMemAddr);
        add("sh_store", 32'h00109023, 2'b10, eStore);
        addFD("shmis", 32'h00109023, 2'b01);
        add("shmis_memaddr", 32'h00109023, 2'b01, eMemAddr);
        add("shmis_store", 32'h00109023, 2'b01, eZero);
        add("shmis_trap", 32'h00109023, 2'b01, eT(CAUSE_STORE_MISAL));
        addFD("ecall", 32'h00000073, 2'b00);
        add("ecall_trap", 32'h00000073, 2'b00, eT(CAUSE_ECALL));
        addFD("csrrw", 32'h34011073, 2'b00);
        add("csrrw_csr", 32'h34011073, 2'b00, eCsr);
        addFD("jal", 32'h0000006F, 2'b00);
        add("jal_jal", 32'h0000006F, 2'b00, eJal);
        addFD("jalr", 32'h00008067, 2'b00);
        add("jalr_jalr", 32'h00008067, 2'b00, eJalr);
        addFD("lui", 32'h000010B7, 2'b00);
        add("lui_lui", 32'h000010B7, 2'b00, eLui);
        add("lui_aluwb", 32'h000010B7, 2'b00, eAluWb);
        addFD("auipc", 32'h00001097, 2'b00);
        add("auipc_aluwb", 32'h00001097, 2'b00, eAluWb);
        addFD("slli_bad", 32'h40109093, 2'b00);
        add("slli_bad_trap", 32'h40109093, 2'b00, eT(CAUSE_ILLEGAL));
        addFD("srai", 32'h4010D093, 2'b00);
        add("srai_itype", 32'h4010D093, 2'b00, eI(OPSRA));
        add("srai_aluwb", 32'h4010D093, 2'b00, eAluWb);
        addFD("mul", 32'h022081B3, 2'b00);
        add("mul_trap", 32'h022081B3, 2'b00, eT(CAUSE_ILLEGAL));
        addFD("addi", 32'h00100093, 2'b00);
        add("addi_itype", 32'h00100093, 2'b00, eI(OPADD));
        add("addi_aluwb", 32'h00100093, 2'b00, eAluWb);

        iRST = 1'b1;
        bus.iInstr   = 32'h0;
        bus.iAddrLow = 2'b00;
        @(negedge iCLK);
        #1 check("reset_state", obs, eFetch);
        iRST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.iInstr   = vecs[i].instr;
            bus.iAddrLow = vecs[i].addrLow;
            #1 check(vecs[i].name, obs, vecs[i].expOut);
            @(negedge iCLK);
        end

        // Reset asserted mid-cycle while in LOAD must return to FETCH at once.
        bus.iInstr   = 32'h0000A283;
        bus.iAddrLow = 2'b00;
        #1 check("rl_fetch", obs, eFetch);
        @(negedge iCLK);
        #1 check("rl_decode", obs, eDecode);
        @(negedge iCLK);
        #1 check("rl_memaddr", obs, eMemAddr);
        @(negedge iCLK);
        #1 check("rl_load", obs, eLoad);
        #1 iRST = 1'b1;
        #1 check("rl_async_reset", obs, eFetch);
        @(posedge iCLK);
        #1 check("rl_reset_held", obs, eFetch);
        @(negedge iCLK);
        iRST = 1'b0;
        #1 check("rl_released", obs, eFetch);
        @(negedge iCLK);
        #1 check("rl_restart_decode", obs, eDecode);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/control_multi_fsm.md
CONTROL_MULTI_FSM -- requirements
Module: control_multi_fsm

Interface
REQ-001 SHALL have no parameters; reset iRST, asynchronous, active-high; clock iCLK.
REQ-002 iCLK  in  1  datapath clock; state register updates on rising edge.
REQ-003 iRST  in  1  asynchronous active-high reset.
REQ-004 iInstr  in  32  current IR contents from the datapath.
REQ-005 iAddrLow  in  2  ALUOut[1:0] (effective address low bits).
REQ-006 oEscreveIR  out  1  IR load enable.
REQ-007 oEscrevePC  out  1  unconditional PC write.
REQ-008 oEscrevePCCond  out  1  PC write qualified by branch outcome.
REQ-009 oEscrevePCBack  out  1  PCBack <= PC.
REQ-010 oOrigAULA  out  2  ALU A select: 00 A, 01 PC, 10 PCBack, 11 zero.
REQ-011 oOrigBULA  out  2  ALU B select: 00 B, 01 const 4, 10 immediate.
REQ-012 oMem2Reg  out  2  writeback select: 00 ALUOut, 01 PC, 10 MDR.
REQ-013 oOrigPC  out  2  PC source: 00 ALU result, 01 ALUOut, 10 ALU result with bit0 cleared.
REQ-014 oIouD  out  1  memory address: 0 PC, 1 ALUOut.
REQ-015 oRegWrite, oMemWrite, oMemRead  out  1 each  register-file write, bus write, bus read strobes.
REQ-016 oALUControl  out  5  ALU operation code (OP* constants).
REQ-017 oRegWriteCSR  out  1  CSR file write enable.
REQ-018 oInstrucaoCSR  out  1  marks active CSR instruction.
REQ-019 oWriteCSROrFPULA  out  1  selects CSR read data onto register writeback.
REQ-020 oDesalinhado  out  1  selects UTVEC as next PC.
REQ-021 oWriteUcause  out  4  trap cause code; nonzero only in TRAP.

Function
REQ-022 States SHALL be FETCH, DECODE, MEMADDR, LOAD, LOADWB, STORE, RTYPE, ITYPE, ALUWB, BRANCH, JAL, JALR, LUI, CSR, TRAP; outputs SHALL be Moore decode of state plus iInstr fields; unlisted outputs 0.
REQ-023 FETCH: IouD=0, MemRead=1, EscreveIR=1, EscrevePCBack=1, OrigA=01, OrigB=01, ADD, OrigPC=00, EscrevePC=1; -> DECODE.
REQ-024 DECODE: OrigA=10, OrigB=10, ADD (branch/JAL/AUIPC target to ALUOut); next by opcode: load/store->MEMADDR, 0110011->RTYPE, 0010011->ITYPE, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->ALUWB, 1110011->CSR/TRAP, other->TRAP cause 0010.
REQ-025 MEMADDR: OrigA=00, OrigB=10, ADD; -> LOAD or STORE.
REQ-026 LOAD/STORE: misaligned (word iAddrLow!=00; half iAddrLow[0]=1) -> TRAP cause 0100 (load)/0110 (store), no strobe; else IouD=1 plus MemRead (->LOADWB) or MemWrite (->FETCH).
REQ-027 LOADWB: Mem2Reg=10, RegWrite=1; -> FETCH.
REQ-028 RTYPE: OrigA=00, OrigB=00; ITYPE: OrigA=00, OrigB=10; both -> ALUWB. funct3 map: 000 ADD (SUB if R-type and iInstr[30]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by iInstr[30], 110 OR, 111 AND; R-type funct7 not 0000000/0100000, or bad shift-immediate funct7, -> TRAP cause 0010 instead.
REQ-029 ALUWB: Mem2Reg=00, RegWrite=1; -> FETCH (AUIPC uses ALUOut computed in DECODE).
REQ-030 BRANCH: OrigA=00, OrigB=00, EscrevePCCond=1, OrigPC=01; -> FETCH.
REQ-031 JAL: Mem2Reg=01, RegWrite=1, EscrevePC=1, OrigPC=01; JALR: OrigA=00, OrigB=10, ADD, OrigPC=10, EscrevePC=1, Mem2Reg=01, RegWrite=1; rd receives PC+4 on same edge as PC update; both -> FETCH.
REQ-032 LUI: OrigA=11, OrigB=10, ADD; -> ALUWB.
REQ-033 SYSTEM: funct3!=000 -> CSR (InstrucaoCSR=1, RegWriteCSR=1, WriteCSROrFPULA=1, RegWrite=1; -> FETCH); iInstr=0x00000073 -> TRAP cause 1000; other funct3=000 -> TRAP cause 0010.
REQ-034 Cause SHALL be latched in a 4-bit register on TRAP entry; TRAP: oWriteUcause=cause, oDesalinhado=1, EscrevePC=1, exactly one cycle; -> FETCH, cause cleared.

Reset
REQ-035 iRST SHALL force state FETCH and cause 0 immediately, including mid-instruction; outputs then equal FETCH decode, oMemWrite=0, oRegWrite=0, oWriteUcause=0.

Structure
REQ-036 State encoding, opcodes, OP* ALU codes and cause codes SHALL live in shared Parametros package; ALU-operation decoding SHALL be sub-module alu_op_dec.

Verification
REQ-037 Release reset -> FETCH: oMemRead=1, oEscreveIR=1, oEscrevePC=1, oIouD=0, oMemWrite=0.
REQ-038 0x002081B3 (add) -> FETCH,DECODE,RTYPE,ALUWB,FETCH; OPADD in RTYPE; oRegWrite=1 only in ALUWB.
REQ-039 0x0000A283 (lw), iAddrLow=00 -> 5 cycles, oMem2Reg=10 in LOADWB; iAddrLow=10 -> TRAP, oWriteUcause=0100.
REQ-040 0x00000463 (beq) -> 3 cycles; BRANCH: oEscrevePCCond=1, oOrigPC=01.
REQ-041 0xFFFFFFFF -> DECODE->TRAP: oWriteUcause=0010, oDesalinhado=1, oEscrevePC=1; then FETCH.
REQ-042 iRST pulsed during LOAD -> FETCH immediately, oMemRead stays FETCH value, no writeback strobe.
